// File: rtl/alu_pipeline_buf.sv
// alu_pipeline_buf: three-stage integer ALU pipe for an out-of-order core.
//   OC (operand collect, 1 entry) -> EX (1 entry) -> WB FIFO (WB_BUF_DEPTH entries).
// Ports:
//   CLK, nRST                      clock, synchronous active-low reset
//   valid_in/ready_out             issue handshake from the issue queue (ready_out combinational)
//   op_in, is_imm_in, imm_in       opcode {funct7[5],funct3} and immediate operand B
//   A_unneeded_in                  operand A is constant 0
//   A/B_forward_in, A/B_bank_in    operand source flags and bank selects
//   A/B_reg_read_valid_in          PRF read data for the operand is valid this cycle
//   reg_read_data_by_bank_in       PRF read data per bank
//   forward_data_by_bank_in        forward bus data per bank
//   dest_PR_in                     destination physical register
//   WB_valid_out/WB_ready_in       writeback handshake, WB_data_out/WB_PR_out = FIFO head
module alu_pipeline_buf #(
  parameter int unsigned PRF_BANK_COUNT = 4,
  parameter int unsigned PR_COUNT       = 64,
  parameter int unsigned WB_BUF_DEPTH   = 2,
  localparam int unsigned LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  localparam int unsigned LOG_PR_COUNT       = $clog2(PR_COUNT)
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic                                 valid_in,
  input  logic [3:0]                           op_in,
  input  logic                                 is_imm_in,
  input  logic [31:0]                          imm_in,
  input  logic                                 A_unneeded_in,
  input  logic                                 A_forward_in,
  input  logic                                 B_forward_in,
  input  logic [LOG_PRF_BANK_COUNT-1:0]        A_bank_in,
  input  logic [LOG_PRF_BANK_COUNT-1:0]        B_bank_in,
  input  logic [LOG_PR_COUNT-1:0]              dest_PR_in,
  input  logic                                 A_reg_read_valid_in,
  input  logic                                 B_reg_read_valid_in,
  input  logic [PRF_BANK_COUNT-1:0][31:0]      reg_read_data_by_bank_in,
  input  logic [PRF_BANK_COUNT-1:0][31:0]      forward_data_by_bank_in,
  input  logic                                 WB_ready_in,
  output logic                                 ready_out,
  output logic                                 WB_valid_out,
  output logic [31:0]                          WB_data_out,
  output logic [LOG_PR_COUNT-1:0]              WB_PR_out
);

  localparam int unsigned LOG_WB = $clog2(WB_BUF_DEPTH);
  localparam int unsigned CNT_W  = LOG_WB + 1;

  typedef struct packed {
    logic [31:0]             data;
    logic [LOG_PR_COUNT-1:0] pr;
  } wb_entry_t;

  // OC stage state
  logic                          oc_valid_q, oc_valid_d;
  logic                          oc_first_q, oc_first_d;
  logic [3:0]                    oc_op_q, oc_op_d;
  logic [LOG_PR_COUNT-1:0]       oc_dest_q, oc_dest_d;
  logic                          oc_a_coll_q, oc_a_coll_d;
  logic                          oc_b_coll_q, oc_b_coll_d;
  logic [31:0]                   oc_a_data_q, oc_a_data_d;
  logic [31:0]                   oc_b_data_q, oc_b_data_d;
  logic [LOG_PRF_BANK_COUNT-1:0] oc_a_bank_q, oc_a_bank_d;
  logic [LOG_PRF_BANK_COUNT-1:0] oc_b_bank_q, oc_b_bank_d;
  logic                          oc_a_fwd_q, oc_a_fwd_d;
  logic                          oc_b_fwd_q, oc_b_fwd_d;

  // EX stage state
  logic                          ex_valid_q, ex_valid_d;
  logic [3:0]                    ex_op_q, ex_op_d;
  logic [31:0]                   ex_a_q, ex_a_d;
  logic [31:0]                   ex_b_q, ex_b_d;
  logic [LOG_PR_COUNT-1:0]       ex_dest_q, ex_dest_d;

  // WB FIFO state
  wb_entry_t                     fifo_mem_q [WB_BUF_DEPTH];
  wb_entry_t                     fifo_mem_d [WB_BUF_DEPTH];
  logic [LOG_WB-1:0]             wr_ptr_q, wr_ptr_d;
  logic [LOG_WB-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;

  logic        a_fwd_hit, a_rd_hit, a_ready;
  logic        b_fwd_hit, b_rd_hit, b_ready;
  logic [31:0] a_value, b_value;
  logic        oc_advance, ex_advance, fifo_full, pop, push, accept;
  logic [31:0] ex_result;

  // ALU
  always_comb begin
    ex_result = '0;
    case (ex_op_q)
      4'b0000: ex_result = ex_a_q + ex_b_q;
      4'b1000: ex_result = ex_a_q - ex_b_q;
      4'b0001: ex_result = ex_a_q << ex_b_q[4:0];
      4'b0010: ex_result = {31'd0, ($signed(ex_a_q) < $signed(ex_b_q))};
      4'b0011: ex_result = {31'd0, (ex_a_q < ex_b_q)};
      4'b0100: ex_result = ex_a_q ^ ex_b_q;
      4'b0101: ex_result = ex_a_q >> ex_b_q[4:0];
      4'b1101: ex_result = $signed(ex_a_q) >>> ex_b_q[4:0];
      4'b0110: ex_result = ex_a_q | ex_b_q;
      4'b0111: ex_result = ex_a_q & ex_b_q;
      default: ex_result = '0;
    endcase
  end

  // Operand arrival and stage handshakes; forward data is only valid in the first OC cycle
  always_comb begin
    a_fwd_hit = oc_first_q && !oc_a_coll_q && oc_a_fwd_q;
    a_rd_hit  = !oc_a_coll_q && A_reg_read_valid_in;
    b_fwd_hit = oc_first_q && !oc_b_coll_q && oc_b_fwd_q;
    b_rd_hit  = !oc_b_coll_q && B_reg_read_valid_in;
    a_ready   = oc_a_coll_q || a_fwd_hit || a_rd_hit;
    b_ready   = oc_b_coll_q || b_fwd_hit || b_rd_hit;

    a_value = oc_a_data_q;
    if (!oc_a_coll_q) begin
      a_value = a_fwd_hit ? forward_data_by_bank_in[oc_a_bank_q]
                          : reg_read_data_by_bank_in[oc_a_bank_q];
    end
    b_value = oc_b_data_q;
    if (!oc_b_coll_q) begin
      b_value = b_fwd_hit ? forward_data_by_bank_in[oc_b_bank_q]
                          : reg_read_data_by_bank_in[oc_b_bank_q];
    end

    fifo_full  = (count_q == CNT_W'(WB_BUF_DEPTH));
    pop        = WB_valid_out && WB_ready_in;
    ex_advance = ex_valid_q && (!fifo_full || pop);
    push       = ex_advance;
    oc_advance = oc_valid_q && a_ready && b_ready && (!ex_valid_q || ex_advance);
    ready_out  = nRST && (!oc_valid_q || oc_advance);
    accept     = valid_in && ready_out;
  end

  // Next-state logic for all stages
  always_comb begin
    oc_valid_d  = oc_valid_q;
    oc_first_d  = oc_first_q;
    oc_op_d     = oc_op_q;
    oc_dest_d   = oc_dest_q;
    oc_a_coll_d = oc_a_coll_q;
    oc_b_coll_d = oc_b_coll_q;
    oc_a_data_d = oc_a_data_q;
    oc_b_data_d = oc_b_data_q;
    oc_a_bank_d = oc_a_bank_q;
    oc_b_bank_d = oc_b_bank_q;
    oc_a_fwd_d  = oc_a_fwd_q;
    oc_b_fwd_d  = oc_b_fwd_q;
    ex_valid_d  = ex_valid_q;
    ex_op_d     = ex_op_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_dest_d   = ex_dest_q;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    // OC: drain, or hold and keep whatever operands arrived this cycle
    if (oc_advance) begin
      oc_valid_d = 1'b0;
    end else if (oc_valid_q) begin
      oc_first_d = 1'b0;
      if (a_fwd_hit || a_rd_hit) begin
        oc_a_coll_d = 1'b1;
        oc_a_data_d = a_value;
      end
      if (b_fwd_hit || b_rd_hit) begin
        oc_b_coll_d = 1'b1;
        oc_b_data_d = b_value;
      end
    end

    if (accept) begin
      oc_valid_d  = 1'b1;
      oc_first_d  = 1'b1;
      oc_op_d     = op_in;
      oc_dest_d   = dest_PR_in;
      oc_a_coll_d = A_unneeded_in;
      oc_a_data_d = '0;
      oc_b_coll_d = is_imm_in;
      oc_b_data_d = is_imm_in ? imm_in : '0;
      oc_a_bank_d = A_bank_in;
      oc_b_bank_d = B_bank_in;
      oc_a_fwd_d  = A_forward_in;
      oc_b_fwd_d  = B_forward_in;
    end

    // EX
    if (oc_advance) begin
      ex_valid_d = 1'b1;
      ex_op_d    = oc_op_q;
      ex_a_d     = a_value;
      ex_b_d     = b_value;
      ex_dest_d  = oc_dest_q;
    end else if (ex_advance) begin
      ex_valid_d = 1'b0;
    end

    // WB FIFO; pointers wrap naturally since depth is a power of two
    if (push) begin
      fifo_mem_d[wr_ptr_q] = '{data: ex_result, pr: ex_dest_q};
      wr_ptr_d             = wr_ptr_q + LOG_WB'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + LOG_WB'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      oc_valid_q  <= 1'b0;
      oc_first_q  <= 1'b0;
      oc_op_q     <= '0;
      oc_dest_q   <= '0;
      oc_a_coll_q <= 1'b0;
      oc_b_coll_q <= 1'b0;
      oc_a_data_q <= '0;
      oc_b_data_q <= '0;
      oc_a_bank_q <= '0;
      oc_b_bank_q <= '0;
      oc_a_fwd_q  <= 1'b0;
      oc_b_fwd_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_dest_q   <= '0;
      for (int i = 0; i < WB_BUF_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      oc_valid_q  <= oc_valid_d;
      oc_first_q  <= oc_first_d;
      oc_op_q     <= oc_op_d;
      oc_dest_q   <= oc_dest_d;
      oc_a_coll_q <= oc_a_coll_d;
      oc_b_coll_q <= oc_b_coll_d;
      oc_a_data_q <= oc_a_data_d;
      oc_b_data_q <= oc_b_data_d;
      oc_a_bank_q <= oc_a_bank_d;
      oc_b_bank_q <= oc_b_bank_d;
      oc_a_fwd_q  <= oc_a_fwd_d;
      oc_b_fwd_q  <= oc_b_fwd_d;
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_dest_q   <= ex_dest_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Writeback presents the FIFO head
  assign WB_valid_out = (count_q != '0);
  assign WB_data_out  = fifo_mem_q[rd_ptr_q].data;
  assign WB_PR_out    = fifo_mem_q[rd_ptr_q].pr;

endmodule

// File: tb/tb_alu_pipeline_buf.sv
// Directed self-checking bench for alu_pipeline_buf (default parameters).
module tb_alu_pipeline_buf;

  localparam int unsigned BANKS = 4;
  localparam int unsigned PRS   = 64;
  localparam int unsigned DEPTH = 2;

  logic                   CLK = 1'b0;
  logic                   nRST;
  logic                   valid_in;
  logic [3:0]             op_in;
  logic                   is_imm_in;
  logic [31:0]            imm_in;
  logic                   A_unneeded_in;
  logic                   A_forward_in;
  logic                   B_forward_in;
  logic [1:0]             A_bank_in;
  logic [1:0]             B_bank_in;
  logic [5:0]             dest_PR_in;
  logic                   A_reg_read_valid_in;
  logic                   B_reg_read_valid_in;
  logic [BANKS-1:0][31:0] reg_read_data_by_bank_in;
  logic [BANKS-1:0][31:0] forward_data_by_bank_in;
  logic                   WB_ready_in;
  logic                   ready_out;
  logic                   WB_valid_out;
  logic [31:0]            WB_data_out;
  logic [5:0]             WB_PR_out;

  int checks = 0;
  int errors = 0;

  alu_pipeline_buf #(
    .PRF_BANK_COUNT(BANKS),
    .PR_COUNT(PRS),
    .WB_BUF_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .valid_in(valid_in),
    .op_in(op_in),
    .is_imm_in(is_imm_in),
    .imm_in(imm_in),
    .A_unneeded_in(A_unneeded_in),
    .A_forward_in(A_forward_in),
    .B_forward_in(B_forward_in),
    .A_bank_in(A_bank_in),
    .B_bank_in(B_bank_in),
    .dest_PR_in(dest_PR_in),
    .A_reg_read_valid_in(A_reg_read_valid_in),
    .B_reg_read_valid_in(B_reg_read_valid_in),
    .reg_read_data_by_bank_in(reg_read_data_by_bank_in),
    .forward_data_by_bank_in(forward_data_by_bank_in),
    .WB_ready_in(WB_ready_in),
    .ready_out(ready_out),
    .WB_valid_out(WB_valid_out),
    .WB_data_out(WB_data_out),
    .WB_PR_out(WB_PR_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    valid_in                 = 1'b0;
    op_in                    = 4'd0;
    is_imm_in                = 1'b0;
    imm_in                   = 32'd0;
    A_unneeded_in            = 1'b0;
    A_forward_in             = 1'b0;
    B_forward_in             = 1'b0;
    A_bank_in                = 2'd0;
    B_bank_in                = 2'd0;
    dest_PR_in               = 6'd0;
    A_reg_read_valid_in      = 1'b0;
    B_reg_read_valid_in      = 1'b0;
    reg_read_data_by_bank_in = '0;
    forward_data_by_bank_in  = '0;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    idle();
    WB_ready_in = 1'b1;
    tick();
    valid_in = 1'b1;
    tick();
    #1;
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", ready_out); end
    checks++;
    if (WB_valid_out !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", WB_valid_out); end
    valid_in = 1'b0;
    nRST = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL after_reset_ready: got %b want 1", ready_out); end
    checks++;
    if (WB_data_out !== 32'd0) begin errors++; $display("FAIL after_reset_data: got %h want 0", WB_data_out); end
    checks++;
    if (WB_PR_out !== 6'd0) begin errors++; $display("FAIL after_reset_pr: got %0d want 0", WB_PR_out); end
    tick();
    checks++;
    if (WB_valid_out !== 1'b0) begin errors++; $display("FAIL after_reset_wb_valid: got %b want 0", WB_valid_out); end
  endtask

  // A forwarded from bank 2 in first OC cycle, B = imm
  task automatic test_add_imm;
    idle();
    WB_ready_in             = 1'b1;
    valid_in                = 1'b1;
    op_in                   = 4'b0000;
    is_imm_in               = 1'b1;
    imm_in                  = 32'hFFFF_FFFF;
    A_forward_in            = 1'b1;
    A_bank_in               = 2'd2;
    dest_PR_in              = 6'd7;
    forward_data_by_bank_in = {4{32'hDEAD_BEEF}};
    #1;
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL add_issue_ready: got %b want 1", ready_out); end
    tick();
    idle();
    forward_data_by_bank_in    = {4{32'hAAAA_AAAA}};
    forward_data_by_bank_in[2] = 32'h0000_0005;
    tick();
    idle();
    forward_data_by_bank_in = {4{32'hDEAD_BEEF}};
    #1;
    checks++;
    if (WB_valid_out !== 1'b0) begin errors++; $display("FAIL add_early_wb: got %b want 0", WB_valid_out); end
    tick();
    checks++;
    if (WB_valid_out !== 1'b1) begin errors++; $display("FAIL add_wb_valid: got %b want 1", WB_valid_out); end
    checks++;
    if (WB_data_out !== 32'h0000_0004) begin errors++; $display("FAIL add_wb_data: got %h want 00000004", WB_data_out); end
    checks++;
    if (WB_PR_out !== 6'd7) begin errors++; $display("FAIL add_wb_pr: got %0d want 7", WB_PR_out); end
    tick();
    checks++;
    if (WB_valid_out !== 1'b0) begin errors++; $display("FAIL add_wb_popped: got %b want 0", WB_valid_out); end
  endtask

  // A from PRF arrives two cycles late
  task automatic test_sra_late;
    idle();
    WB_ready_in = 1'b1;
    valid_in    = 1'b1;
    op_in       = 4'b1101;
    is_imm_in   = 1'b1;
    imm_in      = 32'd4;
    A_bank_in   = 2'd1;
    dest_PR_in  = 6'd3;
    tick();
    for (int c = 0; c < 2; c++) begin
      idle();
      reg_read_data_by_bank_in = {4{32'h1234_5678}};
      #1;
      checks++;
      if (ready_out !== 1'b0) begin errors++; $display("FAIL sra_wait_ready cycle %0d: got %b want 0", c, ready_out); end
      tick();
    end
    idle();
    reg_read_data_by_bank_in    = {4{32'h1234_5678}};
    reg_read_data_by_bank_in[1] = 32'h8000_0000;
    A_reg_read_valid_in         = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL sra_arrive_ready: got %b want 1", ready_out); end
    tick();
    idle();
    tick();
    checks++;
    if (WB_valid_out !== 1'b1) begin errors++; $display("FAIL sra_wb_valid: got %b want 1", WB_valid_out); end
    checks++;
    if (WB_data_out !== 32'hF800_0000) begin errors++; $display("FAIL sra_wb_data: got %h want f8000000", WB_data_out); end
    checks++;
    if (WB_PR_out !== 6'd3) begin errors++; $display("FAIL sra_wb_pr: got %0d want 3", WB_PR_out); end
    tick();
  endtask

  // Back-to-back ops at one per cycle covering every opcode
  task automatic test_alu_ops;
    localparam int N = 11;
    logic [3:0]  ops [N] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                             4'b0101, 4'b0110, 4'b0111, 4'b1111, 4'b1101};
    logic [31:0] as  [N] = '{32'h7, 32'h5, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                             32'h8000_0000, 32'h1234_0000, 32'hFFFF_0000, 32'h5, 32'h7FFF_FFF0};
    logic [31:0] bs  [N] = '{32'h8, 32'h8, 32'h24, 32'h1, 32'h1, 32'h0FF0_0FF0,
                             32'h4, 32'h0000_5678, 32'h0F0F_0F0F, 32'h3, 32'h4};
    logic [31:0] exp [N] = '{32'hF, 32'hFFFF_FFFD, 32'h30, 32'h1, 32'h0, 32'hFF00_FF00,
                             32'h0800_0000, 32'h1234_5678, 32'h0F0F_0000, 32'h0, 32'h07FF_FFFF};
    for (int i = 0; i < N + 2; i++) begin
      idle();
      WB_ready_in = 1'b1;
      if (i < N) begin
        valid_in     = 1'b1;
        op_in        = ops[i];
        is_imm_in    = 1'b1;
        imm_in       = bs[i];
        A_forward_in = 1'b1;
        dest_PR_in   = 6'(i + 1);
      end
      if (i >= 1 && i <= N) forward_data_by_bank_in[0] = as[i-1];
      #1;
      if (i < N) begin
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL alu_ready op %0d: got %b want 1", i, ready_out); end
      end
      tick();
      if (i >= 2) begin
        checks++;
        if (WB_valid_out !== 1'b1) begin errors++; $display("FAIL alu_wb_valid op %0d: got %b want 1", i - 2, WB_valid_out); end
        checks++;
        if (WB_data_out !== exp[i-2]) begin errors++; $display("FAIL alu_wb_data op %0d: got %h want %h", i - 2, WB_data_out, exp[i-2]); end
        checks++;
        if (WB_PR_out !== 6'(i - 1)) begin errors++; $display("FAIL alu_wb_pr op %0d: got %0d want %0d", i - 2, WB_PR_out, i - 1); end
      end
    end
    idle();
    tick();
    checks++;
    if (WB_valid_out !== 1'b0) begin errors++; $display("FAIL alu_drained: got %b want 0", WB_valid_out); end
  endtask

  // Stall with WB_ready_in low, then release and drain in order
  task automatic test_backpressure;
    idle();
    WB_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      valid_in      = 1'b1;
      op_in         = 4'b0000;
      A_unneeded_in = 1'b1;
      is_imm_in     = 1'b1;
      imm_in        = 32'(10 + i);
      dest_PR_in    = 6'(i + 1);
      #1;
      checks++;
      if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_issue_ready op %0d: got %b want 1", i, ready_out); end
      tick();
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_stall_ready cycle %0d: got %b want 0", c, ready_out); end
      checks++;
      if (WB_data_out !== 32'd10) begin errors++; $display("FAIL bp_stall_head cycle %0d: got %h want 0000000a", c, WB_data_out); end
      tick();
    end
    WB_ready_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", ready_out); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (WB_valid_out !== 1'b1) begin errors++; $display("FAIL bp_wb_valid %0d: got %b want 1", j, WB_valid_out); end
      checks++;
      if (WB_data_out !== 32'(10 + j)) begin errors++; $display("FAIL bp_wb_data %0d: got %h want %h", j, WB_data_out, 32'(10 + j)); end
      checks++;
      if (WB_PR_out !== 6'(j + 1)) begin errors++; $display("FAIL bp_wb_pr %0d: got %0d want %0d", j, WB_PR_out, j + 1); end
      tick();
    end
    checks++;
    if (WB_valid_out !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", WB_valid_out); end
  endtask

  // Reset with FIFO full, EX busy and OC waiting on a PRF read
  task automatic test_reset_midop;
    idle();
    WB_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      valid_in      = 1'b1;
      op_in         = 4'b0000;
      A_unneeded_in = (i < 3);
      is_imm_in     = 1'b1;
      imm_in        = 32'(32'h100 + i);
      dest_PR_in    = 6'(20 + i);
      tick();
    end
    idle();
    #1;
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL mid_full_ready: got %b want 0", ready_out); end
    checks++;
    if (WB_valid_out !== 1'b1) begin errors++; $display("FAIL mid_full_valid: got %b want 1", WB_valid_out); end
    nRST = 1'b0;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL mid_in_reset_ready: got %b want 0", ready_out); end
    tick();
    checks++;
    if (WB_valid_out !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", WB_valid_out); end
    checks++;
    if (WB_data_out !== 32'd0) begin errors++; $display("FAIL mid_reset_data: got %h want 0", WB_data_out); end
    nRST                        = 1'b1;
    WB_ready_in                 = 1'b1;
    A_reg_read_valid_in         = 1'b1;
    reg_read_data_by_bank_in[0] = 32'h55;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b want 1", ready_out); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (WB_valid_out !== 1'b0) begin errors++; $display("FAIL mid_stale_wb cycle %0d: got %b want 0", c, WB_valid_out); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_sra_late();
    test_alu_ops();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
